snp_bus_arb: RTL and testbench

//  Snoop-bus arbiter/sequencer shared by NUM_CORES L1 request controllers. Grants one miss/upgrade

---
 rtl/snp_bus_arb_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 33 +++
 rtl/snp_bus_arb.sv | 150 +++++++++++++++
 tb/tb_snp_bus_arb.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/snp_bus_arb_pkg.sv
// Shared cache definitions: snoop type/response encodings and the snoop-bus arbiter FSM states.
package snp_bus_arb_pkg;

  localparam logic [2:0] SDT_RD  = 3'd0;
  localparam logic [2:0] SDT_RFO = 3'd1;
  localparam logic [2:0] SDT_INV = 3'd2;

  localparam logic [2:0] SDR_OKAY  = 3'd0;
  localparam logic [2:0] SDR_SNOOP = 3'd1;
  localparam logic [2:0] SDR_FETCH = 3'd2;

  typedef enum logic [1:0] {IDLE, BCAST, WAIT, RESP} snp_arb_state_e;

  // Any encoding other than RFO/INV is broadcast as a plain read.
  function automatic logic [2:0] snp_norm_type(input logic [2:0] t);
    return ((t == SDT_RFO) || (t == SDT_INV)) ? t : SDT_RD;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr_i, wrapping.
module rr_arbiter #(
  parameter int unsigned N    = 4,
  parameter int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req_i,
  input  logic [IdxW-1:0] ptr_i,
  output logic [N-1:0]    gnt_o,
  output logic [IdxW-1:0] idx_o,
  output logic            vld_o
);

  always_comb begin
    int unsigned c;
    logic [IdxW-1:0] ci;
    c     = 0;
    ci    = '0;
    gnt_o = '0;
    idx_o = '0;
    vld_o = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      c = 32'(ptr_i) + k;
      if (c >= N) c = c - N;
      ci = IdxW'(c);
      if (!vld_o && req_i[ci]) begin
        vld_o     = 1'b1;
        gnt_o[ci] = 1'b1;
        idx_o     = ci;
      end
    end
  end

endmodule

// File: rtl/snp_bus_arb.sv
// Snoop-bus arbiter: grants one request round-robin, broadcasts it, gathers snoop
// responses and returns a single combined response to the requester.
module snp_bus_arb
  import snp_bus_arb_pkg::*;
#(
  parameter int unsigned NUM_CORES   = 4,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned RSP_TIMEOUT = 16,
  parameter int unsigned SrcW        = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic                            clk_i,
  input  logic                            rst_n,
  input  logic [NUM_CORES-1:0]            req_vld_i,
  input  logic [NUM_CORES*3-1:0]          req_type_i,
  input  logic [NUM_CORES*ADDR_WIDTH-1:0] req_addr_i,
  output logic [NUM_CORES-1:0]            gnt_o,
  output logic                            snp_vld_o,
  output logic [2:0]                      snp_type_o,
  output logic [ADDR_WIDTH-1:0]           snp_addr_o,
  output logic [SrcW-1:0]                 snp_src_o,
  input  logic [NUM_CORES-1:0]            snp_rsp_vld_i,
  input  logic [NUM_CORES*3-1:0]          snp_rsp_i,
  output logic [NUM_CORES-1:0]            rsp_vld_o,
  output logic [2:0]                      rsp_o
);

  localparam int unsigned CntW = $clog2(RSP_TIMEOUT);
  localparam logic [CntW-1:0] CntLast = CntW'(RSP_TIMEOUT - 1);

  snp_arb_state_e         state_q, state_d;
  logic [SrcW-1:0]        ptr_q, ptr_d, src_q, src_d;
  logic [2:0]             type_q, type_d, rsp_q, rsp_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [NUM_CORES-1:0]   pending_q, pending_d;
  logic                   has_copy_q, has_copy_d;
  logic [CntW-1:0]        cnt_q, cnt_d;

  logic [NUM_CORES-1:0]   arb_gnt, clr;
  logic [SrcW-1:0]        arb_idx;
  logic                   arb_vld, snoop_hit;
  logic [2:0]             sel_type;
  logic [ADDR_WIDTH-1:0]  sel_addr;

  rr_arbiter #(
    .N    (NUM_CORES),
    .IdxW (SrcW)
  ) u_rr_arbiter (
    .req_i (req_vld_i),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .vld_o (arb_vld)
  );

  always_comb begin
    sel_type = SDT_RD;
    sel_addr = '0;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      if (arb_gnt[i]) begin
        sel_type = req_type_i[i*3 +: 3];
        sel_addr = req_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
  end

  // Only strobes from still-pending cores count; the requester is never pending.
  assign clr = snp_rsp_vld_i & pending_q;

  always_comb begin
    snoop_hit = 1'b0;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      if (clr[i] && (snp_rsp_i[i*3 +: 3] == SDR_SNOOP)) snoop_hit = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    src_d      = src_q;
    type_d     = type_q;
    addr_d     = addr_q;
    pending_d  = pending_q;
    has_copy_d = has_copy_q;
    cnt_d      = cnt_q;
    rsp_d      = rsp_q;
    unique case (state_q)
      IDLE: begin
        if (arb_vld) begin
          src_d      = arb_idx;
          type_d     = snp_norm_type(sel_type);
          addr_d     = sel_addr;
          pending_d  = ~arb_gnt;
          has_copy_d = 1'b0;
          state_d    = BCAST;
        end
      end
      BCAST: begin
        ptr_d   = (src_q == SrcW'(NUM_CORES - 1)) ? '0 : src_q + 1'b1;
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        pending_d  = pending_q & ~clr;
        has_copy_d = has_copy_q | snoop_hit;
        cnt_d      = cnt_q + 1'b1;
        if ((pending_d == '0) || (cnt_q == CntLast)) begin
          state_d = RESP;
          if ((pending_d != '0) || (type_q == SDT_INV)) rsp_d = SDR_OKAY;
          else if (has_copy_d)                          rsp_d = SDR_SNOOP;
          else                                          rsp_d = SDR_FETCH;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      src_q      <= '0;
      type_q     <= SDT_RD;
      addr_q     <= '0;
      pending_q  <= '0;
      has_copy_q <= 1'b0;
      cnt_q      <= '0;
      rsp_q      <= SDR_OKAY;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      src_q      <= src_d;
      type_q     <= type_d;
      addr_q     <= addr_d;
      pending_q  <= pending_d;
      has_copy_q <= has_copy_d;
      cnt_q      <= cnt_d;
      rsp_q      <= rsp_d;
    end
  end

  assign gnt_o      = (state_q == BCAST) ? (NUM_CORES'(1) << src_q) : '0;
  assign snp_vld_o  = (state_q == BCAST);
  assign rsp_vld_o  = (state_q == RESP) ? (NUM_CORES'(1) << src_q) : '0;
  assign snp_type_o = type_q;
  assign snp_addr_o = addr_q;
  assign snp_src_o  = src_q;
  assign rsp_o      = rsp_q;

endmodule

// File: tb/tb_snp_bus_arb.sv
// Directed bench for snp_bus_arb; expected combined responses are queued at stimulus time
// and checked (value and arrival cycle) when rsp_vld fires.
module tb_snp_bus_arb;
  import snp_bus_arb_pkg::*;

  localparam int unsigned N  = 4;
  localparam int unsigned AW = 32;
  localparam int unsigned TO = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_vld = '0;
  logic [N*3-1:0]  req_type = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N-1:0]    gnt;
  logic            snp_vld;
  logic [2:0]      snp_type;
  logic [AW-1:0]   snp_addr;
  logic [1:0]      snp_src;
  logic [N-1:0]    snp_rsp_vld = '0;
  logic [N*3-1:0]  snp_rsp = '0;
  logic [N-1:0]    rsp_vld;
  logic [2:0]      rsp;

  typedef struct {
    int         core;
    logic [2:0] rsp;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;

  snp_bus_arb #(
    .NUM_CORES   (N),
    .ADDR_WIDTH  (AW),
    .RSP_TIMEOUT (TO)
  ) dut (
    .clk_i         (clk),
    .rst_n         (rst_n),
    .req_vld_i     (req_vld),
    .req_type_i    (req_type),
    .req_addr_i    (req_addr),
    .gnt_o         (gnt),
    .snp_vld_o     (snp_vld),
    .snp_type_o    (snp_type),
    .snp_addr_o    (snp_addr),
    .snp_src_o     (snp_src),
    .snp_rsp_vld_i (snp_rsp_vld),
    .snp_rsp_i     (snp_rsp),
    .rsp_vld_o     (rsp_vld),
    .rsp_o         (rsp)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && rsp_vld !== '0) begin
      if (sb.size() == 0) begin
        chk("rsp_unexpected", 64'(rsp_vld), 64'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("rsp_vld", 64'(rsp_vld), 64'(N'(1) << mon_e.core));
        chk("rsp", 64'(rsp), 64'(mon_e.rsp));
        chk("rsp_cyc", 64'(cyc), 64'(mon_e.cyc));
        chk("rsp_gnt_overlap", 64'(gnt), 64'd0);
      end
    end
  end

  task automatic set_req(input int core, input logic [2:0] typ, input logic [AW-1:0] addr);
    req_vld[core]          = 1'b1;
    req_type[core*3 +: 3]  = typ;
    req_addr[core*AW +: AW] = addr;
  endtask

  task automatic wait_gnt(input int core, input logic [2:0] typ, input logic [AW-1:0] addr,
                          output int g);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (gnt !== '0) break;
    end
    g = cyc;
    chk("gnt", 64'(gnt), 64'(N'(1) << core));
    chk("snp_vld", 64'(snp_vld), 64'd1);
    chk("snp_src", 64'(snp_src), 64'(core));
    chk("snp_type", 64'(typ), 64'(snp_type));
    chk("snp_addr", 64'(snp_addr), 64'(addr));
  endtask

  // Drive one cycle of snoop responses starting just after a rising edge.
  task automatic pulse_rsp(input logic [N-1:0] mask, input logic [N*3-1:0] vec);
    snp_rsp_vld = mask;
    snp_rsp     = vec;
    @(posedge clk);
    #1;
    snp_rsp_vld = '0;
    snp_rsp     = '0;
  endtask

  // Grant, then every other core answers SDR_OKAY in the first WAIT cycle.
  task automatic serve(input int core, input logic [2:0] typ, input logic [AW-1:0] addr,
                       input bit drop, input logic [2:0] exp_rsp, output int g);
    wait_gnt(core, typ, addr, g);
    @(posedge clk);
    #1;
    if (drop) req_vld[core] = 1'b0;
    sb.push_back('{core, exp_rsp, g + 2});
    pulse_rsp(~(N'(1) << core), '0);
  endtask

  task automatic drain();
    for (int i = 0; i < 40; i++) begin
      if (sb.size() == 0) break;
      @(posedge clk);
    end
    #1;
    chk("drain", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int g, t0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_gnt", 64'(gnt), 64'd0);
    chk("rst_snp_vld", 64'(snp_vld), 64'd0);
    chk("rst_rsp_vld", 64'(rsp_vld), 64'd0);
    chk("rst_snp_type", 64'(snp_type), 64'(SDT_RD));
    chk("rst_snp_addr", 64'(snp_addr), 64'd0);
    chk("rst_snp_src", 64'(snp_src), 64'd0);
    chk("rst_rsp", 64'(rsp), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single read from core1, all others OKAY: fetch from memory.
    t0 = cyc;
    set_req(1, SDT_RD, 32'h1000_0040);
    serve(1, SDT_RD, 32'h1000_0040, 1'b1, SDR_FETCH, g);
    chk("t1_gnt_latency", 64'(g), 64'(t0 + 1));
    drain();

    // Core2 RFO, responses spread over three cycles; core0 holds a copy.
    set_req(2, SDT_RFO, 32'h2000_0080);
    wait_gnt(2, SDT_RFO, 32'h2000_0080, g);
    @(posedge clk);
    #1;
    req_vld[2] = 1'b0;
    sb.push_back('{2, SDR_SNOOP, g + 4});
    pulse_rsp(4'b0001, {SDR_OKAY, SDR_OKAY, SDR_OKAY, SDR_SNOOP});
    pulse_rsp(4'b0010, '0);
    pulse_rsp(4'b1000, '0);
    drain();

    // Core3 INV, core1 silent: forced completion after RSP_TIMEOUT WAIT cycles.
    set_req(3, SDT_INV, 32'h3000_00c0);
    wait_gnt(3, SDT_INV, 32'h3000_00c0, g);
    @(posedge clk);
    #1;
    req_vld[3] = 1'b0;
    sb.push_back('{3, SDR_OKAY, g + 1 + TO});
    pulse_rsp(4'b0101, '0);
    drain();
    pulse_rsp(4'b0010, {SDR_OKAY, SDR_OKAY, SDR_SNOOP, SDR_OKAY});
    repeat (4) @(negedge clk);
    chk("t4_late_strobe", 64'(rsp_vld), 64'd0);
    @(posedge clk);
    #1;

    // All cores requesting continuously: strict rotation 0,1,2,3,0,...
    for (int c = 0; c < 4; c++) set_req(c, SDT_RD, 32'h4000_0000 + 32'(c * 64));
    for (int k = 0; k < 8; k++) begin
      serve(k % 4, SDT_RD, 32'h4000_0000 + 32'((k % 4) * 64), 1'b0, SDR_FETCH, g);
    end
    req_vld = '0;
    drain();

    // Requester's own SNOOP strobe must not count as a copy.
    set_req(0, SDT_RD, 32'h5000_0100);
    wait_gnt(0, SDT_RD, 32'h5000_0100, g);
    @(posedge clk);
    #1;
    req_vld[0] = 1'b0;
    sb.push_back('{0, SDR_FETCH, g + 3});
    pulse_rsp(4'b0001, {SDR_OKAY, SDR_OKAY, SDR_OKAY, SDR_SNOOP});
    pulse_rsp(4'b1110, '0);
    drain();

    // Reset during WAIT aborts silently; afterwards the pointer is back at core0.
    set_req(2, SDT_RD, 32'h6000_0140);
    wait_gnt(2, SDT_RD, 32'h6000_0140, g);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("t5_gnt", 64'(gnt), 64'd0);
    chk("t5_snp_vld", 64'(snp_vld), 64'd0);
    chk("t5_rsp_vld", 64'(rsp_vld), 64'd0);
    chk("t5_snp_type", 64'(snp_type), 64'(SDT_RD));
    chk("t5_snp_addr", 64'(snp_addr), 64'd0);
    chk("t5_snp_src", 64'(snp_src), 64'd0);
    set_req(3, SDT_RD, 32'h6000_0180);
    @(posedge clk);
    #1 rst_n = 1'b1;
    serve(2, SDT_RD, 32'h6000_0140, 1'b1, SDR_FETCH, g);
    serve(3, SDT_RD, 32'h6000_0180, 1'b1, SDR_FETCH, g);
    drain();

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
